gather_arbiter: RTL and testbench

GATHER_ARBITER -- requirements
Module: gather_arbiter

---
 rtl/gather_arb_pkg.sv | 27 ++
 rtl/gather_arbiter_rr_pick.sv | 28 ++
 rtl/gather_arbiter.sv | 137 +++++++++++++
 tb/tb_gather_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gather_arb_pkg.sv
// ============================================================
// gather_arb_pkg : shared constants for gather_arbiter
// Rev 1.0
// ============================================================
`default_nettype none

// Vector geometry normally arrives from params.svh; defaults keep the slice standalone.
`ifndef XW
`define XW 4
`endif
`ifndef QW
`define QW 8
`endif

package gather_arb_pkg;

  localparam int NREQ_DEF = 4;
  localparam int STAT_W   = 32;
  localparam int VEC_W    = `XW * `QW;

  typedef logic [0:0] arb_state_t;
  localparam arb_state_t ST_IDLE = 1'b0;
  localparam arb_state_t ST_LOCK = 1'b1;

endpackage

`default_nettype wire

// File: rtl/gather_arbiter_rr_pick.sv
// ============================================================
// rr_pick : combinational round-robin winner, search starts at i_ptr
// Rev 1.0
// ============================================================
`default_nettype none

module rr_pick import gather_arb_pkg::*; #(
  parameter int NREQ = NREQ_DEF,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant
);

  logic [NREQ-1:0] w_mask;
  logic [NREQ-1:0] w_hi;
  logic [NREQ-1:0] w_pool;

  // Prefer requesters at or above the pointer; wrap to the full set otherwise.
  assign w_mask  = ~((NREQ'(1) << i_ptr) - NREQ'(1));
  assign w_hi    = i_req & w_mask;
  assign w_pool  = (|w_hi) ? w_hi : i_req;
  assign o_grant = w_pool & (~w_pool + NREQ'(1));

endmodule

`default_nettype wire

// File: rtl/gather_arbiter.sv
// ============================================================
// gather_arbiter : round-robin burst gather of requester vectors onto
//   one tile port. Define GATHER_ARB_STAT_EN for per-requester beat stats.
// Rev 1.0
// ============================================================
`default_nettype none

module gather_arbiter import gather_arb_pkg::*; #(
  parameter int NREQ = NREQ_DEF,
  parameter int BW   = 8
) (
  input  logic                     clk_tl,
  input  logic                     rstn_tl,
  input  logic [NREQ*VEC_W-1:0]    req_data_i,
  input  logic [NREQ-1:0]          req_valid_i,
  output logic [NREQ-1:0]          req_ready_o,
  input  logic [BW-1:0]            cfg_burst_i,
  output logic [VEC_W-1:0]         tl_data_o,
  output logic                     tl_valid_o,
  input  logic                     tl_ready_i,
  output logic [NREQ-1:0]          grant_o,
  output logic [NREQ*STAT_W-1:0]   stat_beats_o
);

  localparam int PW = $clog2(NREQ);

  arb_state_t        r_state;
  logic [NREQ-1:0]   r_grant;
  logic [PW-1:0]     r_ptr;
  logic [BW-1:0]     r_beats;
  logic [VEC_W-1:0]  r_data;
  logic              r_valid;

  logic [NREQ-1:0]   w_win;
  logic [NREQ-1:0]   w_xfer_vec;
  logic              w_can_accept;
  logic              w_xfer;
  logic              w_last;
  logic [BW-1:0]     w_burst_load;
  logic [VEC_W-1:0]  w_sel_data;
  logic [PW-1:0]     w_next_ptr;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_pick (
    .i_req   (req_valid_i),
    .i_ptr   (r_ptr),
    .o_grant (w_win)
  );

  assign w_can_accept = (r_state == ST_LOCK) & (~r_valid | tl_ready_i);
  assign req_ready_o  = r_grant & {NREQ{w_can_accept}};
  assign w_xfer_vec   = req_ready_o & req_valid_i;
  assign w_xfer       = |w_xfer_vec;
  assign w_last       = (r_beats == BW'(1));
  assign w_burst_load = (cfg_burst_i == '0) ? BW'(1) : cfg_burst_i;

  always_comb begin
    w_sel_data = '0;
    w_next_ptr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_grant[i]) begin
        w_sel_data = req_data_i[i*VEC_W +: VEC_W];
        w_next_ptr = (i == NREQ-1) ? '0 : PW'(i + 1);
      end
    end
  end

  // Burst length is captured once at grant; later cfg changes do not reach r_beats.
  always_ff @(posedge clk_tl or negedge rstn_tl) begin
    if (!rstn_tl) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
      r_beats <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|req_valid_i) begin
            r_grant <= w_win;
            r_beats <= w_burst_load;
            r_state <= ST_LOCK;
          end
        end
        ST_LOCK: begin
          if (w_xfer) begin
            r_beats <= r_beats - BW'(1);
            if (w_last) begin
              r_state <= ST_IDLE;
              r_grant <= '0;
              r_ptr   <= w_next_ptr;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_tl or negedge rstn_tl) begin
    if (!rstn_tl) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (w_xfer) begin
      r_data  <= w_sel_data;
      r_valid <= 1'b1;
    end else if (tl_ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign tl_data_o  = r_data;
  assign tl_valid_o = r_valid;
  assign grant_o    = r_grant;

`ifdef GATHER_ARB_STAT_EN
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_stat
    logic [STAT_W-1:0] r_cnt;

    always_ff @(posedge clk_tl or negedge rstn_tl) begin
      if (!rstn_tl) begin
        r_cnt <= '0;
      end else if (w_xfer_vec[gi] && (r_cnt != '1)) begin
        r_cnt <= r_cnt + STAT_W'(1);
      end
    end

    assign stat_beats_o[gi*STAT_W +: STAT_W] = r_cnt;
  end
`else
  assign stat_beats_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gather_arbiter.sv
// ============================================================
// tb_gather_arbiter : randomized scoreboard bench for gather_arbiter
// Rev 1.0
// ============================================================
`default_nettype none

module tb_gather_arbiter;
  import gather_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int BW   = 8;
  localparam int DW   = VEC_W;

  logic                   clk_tl = 1'b0;
  logic                   rstn_tl = 1'b1;
  logic [NREQ*DW-1:0]     req_data_i;
  logic [NREQ-1:0]        req_valid_i;
  logic [NREQ-1:0]        req_ready_o;
  logic [BW-1:0]          cfg_burst_i = BW'(1);
  logic [DW-1:0]          tl_data_o;
  logic                   tl_valid_o;
  logic                   tl_ready_i;
  logic [NREQ-1:0]        grant_o;
  logic [NREQ*STAT_W-1:0] stat_beats_o;

  always #5 clk_tl = ~clk_tl;

  gather_arbiter #(
    .NREQ (NREQ),
    .BW   (BW)
  ) dut (
    .clk_tl       (clk_tl),
    .rstn_tl      (rstn_tl),
    .req_data_i   (req_data_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .cfg_burst_i  (cfg_burst_i),
    .tl_data_o    (tl_data_o),
    .tl_valid_o   (tl_valid_o),
    .tl_ready_i   (tl_ready_i),
    .grant_o      (grant_o),
    .stat_beats_o (stat_beats_o)
  );

  logic [DW-1:0]   srcq [NREQ][$];
  logic [DW-1:0]   exp_data [$];
  logic [NREQ-1:0] exp_grant [$];
  int              rise_q [$];
  logic [NREQ-1:0] en = '0;
  logic [NREQ-1:0] hs_pend = '0;
  bit              rdy_force = 1'b1;
  logic            rdy_val = 1'b1;
  int              rdy_pct = 100;
  int              m_ptr = 0;
  int              exp_stat [NREQ];
  int              sc_cnt [NREQ];
  int              n_cmp = 0;
  int              n_fail = 0;
  int              cyc = 0;
  int              n_out = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic bit src_pending();
    for (int i = 0; i < NREQ; i++)
      if (srcq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  // Requester sources: present queue heads, retire heads accepted on the previous edge.
  always @(negedge clk_tl) begin
    for (int i = 0; i < NREQ; i++)
      if (hs_pend[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
    hs_pend = '0;
    tl_ready_i = rdy_force ? rdy_val : (int'($urandom_range(99, 0)) < rdy_pct);
    for (int i = 0; i < NREQ; i++) begin
      if (en[i] && srcq[i].size() > 0) begin
        req_valid_i[i] = 1'b1;
        req_data_i[i*DW +: DW] = srcq[i][0];
      end else begin
        req_valid_i[i] = 1'b0;
        req_data_i[i*DW +: DW] = DW'($urandom);
      end
    end
    #1;
    hs_pend = req_valid_i & req_ready_o;
  end

  // Monitor: compares tile output and grant order against the scoreboard queues.
  logic [DW-1:0]   prev_data;
  bit              prev_stall = 1'b0;
  logic [NREQ-1:0] prev_grant = '0;

  always @(negedge clk_tl) begin
    #2;
    cyc++;
    if (!rstn_tl) begin
      prev_stall = 1'b0;
      prev_grant = '0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", tl_valid_o, 1);
        check("hold_data", tl_data_o, prev_data);
      end
      if (tl_valid_o && !tl_ready_i) check("stall_ready", req_ready_o, 0);
      if (tl_valid_o && tl_ready_i) begin
        n_out++;
        if (exp_data.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL extra_vec: actual %0h required none", tl_data_o);
        end else begin
          check("tl_data", tl_data_o, exp_data.pop_front());
        end
      end
      if (grant_o != '0 && prev_grant == '0) begin
        rise_q.push_back(cyc);
        if (exp_grant.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL extra_grant: actual %0h required none", grant_o);
        end else begin
          check("grant", grant_o, exp_grant.pop_front());
        end
      end
      prev_stall = tl_valid_o && !tl_ready_i;
      prev_data  = tl_data_o;
      prev_grant = grant_o;
    end
  end

  // Reference model: whole bursts served round-robin from the pointer, pointer moves past winner.
  task automatic run_model(input int cfg);
    logic [DW-1:0] lq [NREQ][$];
    logic [DW-1:0] v;
    int rem [NREQ];
    int b;
    int w;
    b = (cfg == 0) ? 1 : cfg;
    for (int i = 0; i < NREQ; i++) begin
      rem[i] = sc_cnt[i];
      exp_stat[i] += sc_cnt[i];
      for (int k = 0; k < sc_cnt[i]; k++) begin
        v = DW'({$urandom, $urandom});
        srcq[i].push_back(v);
        lq[i].push_back(v);
      end
    end
    w = 0;
    while (w >= 0) begin
      w = -1;
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && rem[(m_ptr + k) % NREQ] > 0) w = (m_ptr + k) % NREQ;
      if (w >= 0) begin
        for (int k = 0; k < b && rem[w] > 0; k++) begin
          exp_data.push_back(lq[w].pop_front());
          rem[w]--;
        end
        exp_grant.push_back(NREQ'(1) << w);
        m_ptr = (w + 1) % NREQ;
      end
    end
  endtask

  task automatic start_scn(input int cfg);
    @(posedge clk_tl); #1;
    cfg_burst_i = BW'(cfg);
    rise_q.delete();
    run_model(cfg);
    en = '1;
  endtask

  task automatic finish_scn();
    int k = 0;
    while ((exp_data.size() > 0 || src_pending()) && k < 4000) begin
      @(posedge clk_tl);
      k++;
    end
    if (k >= 4000) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: actual %0d outstanding required 0", exp_data.size());
      exp_data.delete();
      exp_grant.delete();
      for (int i = 0; i < NREQ; i++) srcq[i].delete();
    end
    repeat (3) @(posedge clk_tl);
    #1;
    check("idle_grant", grant_o, 0);
    check("idle_valid", tl_valid_o, 0);
    check("grant_left", exp_grant.size(), 0);
    for (int i = 0; i < NREQ; i++) begin
`ifdef GATHER_ARB_STAT_EN
      check("stat", stat_beats_o[i*STAT_W +: STAT_W], exp_stat[i]);
`else
      check("stat", stat_beats_o[i*STAT_W +: STAT_W], 0);
`endif
    end
    en = '0;
  endtask

  task automatic check_gaps(input int b);
    for (int i = 1; i < rise_q.size(); i++)
      check("burst_gap", rise_q[i] - rise_q[i-1], b + 1);
  endtask

  task automatic wait_grant();
    int k = 0;
    while (grant_o == '0 && k < 200) begin
      @(posedge clk_tl); #1;
      k++;
    end
    if (k >= 200) begin
      n_cmp++;
      n_fail++;
      $display("FAIL grant_timeout: actual %0h required nonzero", grant_o);
    end
  endtask

  task automatic do_reset();
    @(posedge clk_tl); #3;
    rstn_tl = 1'b0;
    #1;
    check("rst_valid", tl_valid_o, 0);
    check("rst_data", tl_data_o, 0);
    check("rst_grant", grant_o, 0);
    check("rst_ready", req_ready_o, 0);
    check("rst_stat", stat_beats_o != '0, 0);
    en = '0;
    for (int i = 0; i < NREQ; i++) begin
      srcq[i].delete();
      exp_stat[i] = 0;
    end
    exp_data.delete();
    exp_grant.delete();
    rise_q.delete();
    hs_pend = '0;
    m_ptr = 0;
    repeat (3) @(negedge clk_tl);
    #3 rstn_tl = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: actual running required finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int cfg;
    int b;
    for (int i = 0; i < NREQ; i++) exp_stat[i] = 0;
    #2 rstn_tl = 1'b0;
    #1;
    check("por_valid", tl_valid_o, 0);
    check("por_grant", grant_o, 0);
    check("por_data", tl_data_o, 0);
    check("por_stat", stat_beats_o != '0, 0);
    repeat (3) @(negedge clk_tl);
    #3 rstn_tl = 1'b1;
    repeat (3) @(posedge clk_tl);
    #1 check("idle_no_req", grant_o, 0);

    // All four requesting, single-vector grants: 0,1,2,3,0.
    sc_cnt = '{2, 1, 1, 1};
    start_scn(1);
    finish_scn();
    check_gaps(1);

    // Only requester 1, bursts of 3, wins twice.
    sc_cnt = '{0, 6, 0, 0};
    start_scn(3);
    finish_scn();
    check_gaps(3);

    // Burst configuration 0 acts as 1.
    sc_cnt = '{1, 0, 1, 0};
    start_scn(0);
    finish_scn();
    check_gaps(1);

    // Burst length changed while locked must not take effect.
    sc_cnt = '{0, 0, 0, 4};
    start_scn(4);
    wait_grant();
    cfg_burst_i = BW'(1);
    finish_scn();

    // Tile back-pressure for 5 cycles mid-burst.
    sc_cnt = '{4, 0, 0, 0};
    start_scn(4);
    wait_grant();
    @(posedge clk_tl); #1;
    rdy_val = 1'b0;
    repeat (5) @(posedge clk_tl);
    #1 rdy_val = 1'b1;
    finish_scn();

    // Owner drops valid mid-burst: grant is held.
    sc_cnt = '{0, 0, 4, 0};
    start_scn(4);
    wait_grant();
    @(posedge clk_tl); #1;
    en[2] = 1'b0;
    repeat (5) @(posedge clk_tl);
    #1;
    check("owner_gap_grant", grant_o, 4'b0100);
    check("owner_gap_valid", tl_valid_o, 0);
    en[2] = 1'b1;
    finish_scn();

    // Randomized bursts with random tile back-pressure.
    rdy_force = 1'b0;
    for (int it = 0; it < 12; it++) begin
      cfg = int'($urandom_range(3, 0));
      b = (cfg == 0) ? 1 : cfg;
      for (int i = 0; i < NREQ; i++) sc_cnt[i] = b * int'($urandom_range(3, 0));
      rdy_pct = int'($urandom_range(90, 40));
      start_scn(cfg);
      finish_scn();
    end
    rdy_force = 1'b1;
    rdy_val = 1'b1;

    // Move the pointer off 0, then reset in the middle of a 4-beat burst.
    sc_cnt = '{0, 4, 0, 0};
    start_scn(2);
    finish_scn();
    sc_cnt = '{0, 4, 0, 0};
    base = n_out;
    start_scn(4);
    for (int k = 0; k < 200 && n_out < base + 2; k++) @(posedge clk_tl);
    do_reset();
    repeat (2) @(posedge clk_tl);
    #1;
    check("post_rst_grant", grant_o, 0);
    check("post_rst_valid", tl_valid_o, 0);
    sc_cnt = '{1, 0, 1, 0};
    start_scn(1);
    finish_scn();

    // Ten vectors from requester 2 after a clean reset.
    do_reset();
    sc_cnt = '{0, 0, 10, 0};
    start_scn(5);
    finish_scn();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
